axi_master: RTL and testbench

AXI_MASTER -- requirements
Module: axi_master

---
 rtl/axi_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_master.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master.sv
// Single-outstanding AXI3-style burst master: accepts one read or write command,
// runs the address/data/response phases and reports completion with a one-cycle done pulse.
module axi_master #(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             arst,

    // Command interface
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [3:0]       cmd_id,
    input  logic [31:0]      cmd_addr,
    input  logic [3:0]       cmd_len,
    input  logic [2:0]       cmd_size,

    // Write-beat source
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       wr_strb,

    // Read-beat sink
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,

    // Completion
    output logic             done,
    output logic [3:0]       done_id,
    output logic [1:0]       done_resp,
    output logic             done_err,

    // AW channel
    output logic [3:0]       awid,
    output logic [31:0]      awaddr,
    output logic [3:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             awvalid,
    input  logic             awready,
    output logic [1:0]       awlock,
    output logic [3:0]       awcache,
    output logic [2:0]       awprot,
    output logic             awqos,
    output logic             awregion,

    // W channel
    output logic [3:0]       wid,
    output logic [WIDTH-1:0] wdata,
    output logic [3:0]       wstrb,
    output logic             wlast,
    output logic             wvalid,
    input  logic             wready,

    // B channel
    input  logic [3:0]       bid,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready,

    // AR channel
    output logic [3:0]       arid,
    output logic [31:0]      araddr,
    output logic [3:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    output logic [1:0]       arlock,
    output logic [3:0]       arcache,
    output logic [2:0]       arprot,
    output logic             arqos,
    output logic             arregion,

    // R channel
    input  logic [3:0]       rid,
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t      state, state_nxt;

    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [2:0]  size_q;
    logic [3:0]  cnt_q;
    logic [1:0]  resp_q;
    logic        err_q;

    logic        cmd_fire;
    logic        w_fire;
    logic        r_fire;
    logic        cmd_bad;
    logic [13:0] end_off;

    // Byte offset just past the burst within its 4KB page; must not exceed the page.
    assign end_off  = {2'b00, cmd_addr[11:0]} + (14'({1'b0, cmd_len} + 5'd1) << cmd_size);
    assign cmd_bad  = (cmd_size > 3'd2) || (end_off > 14'd4096);

    // cmd_ready is held low while reset is asserted and rises as soon as it is released.
    assign cmd_ready = (state == IDLE) && arst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign w_fire    = (state == WDATA) && wr_valid && wready;
    assign r_fire    = (state == RDATA) && rvalid && rd_ready;

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state defaults to the current state first so no path through this block infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad)        state_nxt = DONE;
                    else if (cmd_write) state_nxt = WADDR;
                    else                state_nxt = RADDR;
                end
            end
            WADDR:   if (awready) state_nxt = WDATA;
            WDATA:   if (w_fire && (cnt_q == len_q)) state_nxt = WRESP;
            WRESP:   if (bvalid) state_nxt = DONE;
            RADDR:   if (arready) state_nxt = RDATA;
            RDATA:   if (r_fire && rlast) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            id_q   <= '0;
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
            cnt_q  <= '0;
            resp_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        id_q   <= cmd_id;
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        size_q <= cmd_size;
                        cnt_q  <= '0;
                        resp_q <= cmd_bad ? 2'b10 : 2'b00;
                        err_q  <= 1'b0;
                    end
                end
                WDATA: begin
                    if (w_fire) cnt_q <= cnt_q + 4'd1;
                end
                WRESP: begin
                    if (bvalid) begin
                        resp_q <= bresp;
                        err_q  <= (bid != id_q);
                    end
                end
                RDATA: begin
                    if (r_fire) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (rresp > resp_q) resp_q <= rresp;
                        // Flag a wrong ID, an early rlast, or a beat past the expected last one.
                        if ((rid != id_q) || (rlast ? (cnt_q != len_q) : (cnt_q == len_q)))
                            err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign awid     = id_q;
    assign awaddr   = addr_q;
    assign awlen    = len_q;
    assign awsize   = size_q;
    assign awburst  = 2'b01;
    assign awvalid  = (state == WADDR);
    assign awlock   = '0;
    assign awcache  = '0;
    assign awprot   = '0;
    assign awqos    = 1'b0;
    assign awregion = 1'b0;

    assign wid      = id_q;
    assign wdata    = wr_data;
    assign wstrb    = wr_strb;
    assign wvalid   = (state == WDATA) && wr_valid;
    assign wlast    = (state == WDATA) && (cnt_q == len_q);
    assign wr_ready = (state == WDATA) && wready;

    assign bready   = (state == WRESP);

    assign arid     = id_q;
    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign arsize   = size_q;
    assign arburst  = 2'b01;
    assign arvalid  = (state == RADDR);
    assign arlock   = '0;
    assign arcache  = '0;
    assign arprot   = '0;
    assign arqos    = 1'b0;
    assign arregion = 1'b0;

    assign rready   = (state == RDATA) && rd_ready;
    assign rd_valid = (state == RDATA) && rvalid;
    assign rd_data  = rdata;
    assign rd_last  = (state == RDATA) && rlast;

    assign done      = (state == DONE);
    assign done_id   = id_q;
    assign done_resp = resp_q;
    assign done_err  = err_q;

endmodule

// File: tb/tb_axi_master.sv
// Scoreboard bench for axi_master: the bench acts as command source and AXI slave,
// queues expected W beats, R beats and completions, and a negedge monitor pops them.
module tb_axi_master;

    localparam int WIDTH = 32;

    logic             aclk;
    logic             arst;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [3:0]       cmd_id, cmd_len;
    logic [31:0]      cmd_addr;
    logic [2:0]       cmd_size;
    logic             wr_valid, wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       wr_strb;
    logic             rd_valid, rd_ready, rd_last;
    logic [WIDTH-1:0] rd_data;
    logic             done, done_err;
    logic [3:0]       done_id;
    logic [1:0]       done_resp;
    logic [3:0]       awid, awlen, awcache;
    logic [31:0]      awaddr;
    logic [2:0]       awsize, awprot;
    logic [1:0]       awburst, awlock;
    logic             awvalid, awready, awqos, awregion;
    logic [3:0]       wid, wstrb;
    logic [WIDTH-1:0] wdata;
    logic             wlast, wvalid, wready;
    logic [3:0]       bid;
    logic [1:0]       bresp;
    logic             bvalid, bready;
    logic [3:0]       arid, arlen, arcache;
    logic [31:0]      araddr;
    logic [2:0]       arsize, arprot;
    logic [1:0]       arburst, arlock;
    logic             arvalid, arready, arqos, arregion;
    logic [3:0]       rid;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       rresp;
    logic             rlast, rvalid, rready;

    axi_master #(.WIDTH(WIDTH)) dut (
        .aclk(aclk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_id(done_id), .done_resp(done_resp), .done_err(done_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arqos(arqos), .arregion(arregion),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; logic err; } done_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
    typedef struct { logic [31:0] data; logic last; } rbeat_t;

    done_t  q_done[$];
    wbeat_t q_w[$];
    rbeat_t q_r[$];

    int checks   = 0;
    int failures = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: outputs are stable between the negedge and the next posedge.
    done_t  m_d;
    wbeat_t m_w;
    rbeat_t m_r;
    always @(negedge aclk) begin
        if (arst) begin
            if (done) begin
                if (q_done.size() == 0) begin
                    check("unexp_done", done, 1'b0);
                end else begin
                    m_d = q_done.pop_front();
                    check("done_id", done_id, m_d.id);
                    check("done_resp", done_resp, m_d.resp);
                    check("done_err", done_err, m_d.err);
                end
            end
            if (wvalid && wready) begin
                if (q_w.size() == 0) begin
                    check("unexp_wbeat", wvalid, 1'b0);
                end else begin
                    m_w = q_w.pop_front();
                    check("wdata", wdata, m_w.data);
                    check("wstrb", wstrb, m_w.strb);
                    check("wlast", wlast, m_w.last);
                    check("wid", wid, awid);
                end
            end
            if (rd_valid && rd_ready) begin
                if (q_r.size() == 0) begin
                    check("unexp_rbeat", rd_valid, 1'b0);
                end else begin
                    m_r = q_r.pop_front();
                    check("rd_data", rd_data, m_r.data);
                    check("rd_last", rd_last, m_r.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id;
        cmd_addr  = addr; cmd_len = len; cmd_size = size;
        @(negedge aclk);
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!cmd_ready) check("cmd_timeout", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_aw(input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        @(negedge aclk);
        while (!awvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("aw_seen", awvalid, 1'b1);
        check("awaddr", awaddr, addr);
        check("awlen", awlen, len);
        awready = 1'b1;
        tick();
        awready = 1'b0;
    endtask

    task automatic wait_ar(input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        @(negedge aclk);
        while (!arvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("ar_seen", arvalid, 1'b1);
        check("araddr", araddr, addr);
        check("arlen", arlen, len);
        check("arburst", arburst, 2'b01);
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // Sends beats [first, first+count); a 3-cycle wr_valid gap precedes beat gap_at.
    task automatic write_beats(input logic [31:0] base, input int first, input int count,
                               input int len, input int gap_at);
        for (int i = first; i < first + count; i++) begin
            if (i == gap_at) begin
                wr_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    @(negedge aclk);
                    check("gap_wvalid", wvalid, 1'b0);
                    check("gap_wlast", wlast, 1'b0);
                    tick();
                end
            end
            wr_valid = 1'b1;
            wready   = 1'b1;
            wr_data  = base + 32'(i);
            wr_strb  = 4'hF ^ 4'(i);
            q_w.push_back('{data: wr_data, strb: wr_strb, last: (i == len)});
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic b_resp(input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        @(negedge aclk);
        while (!bready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("bready", bready, 1'b1);
        bvalid = 1'b1; bid = id; bresp = resp;
        tick();
        bvalid = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
        q_r.push_back('{data: data, last: last});
        rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last; rd_ready = 1'b1;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_done.size() != 0 || q_w.size() != 0 || q_r.size() != 0) && n < 30) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check("drain_done", q_done.size(), 0);
        check("drain_w", q_w.size(), 0);
        check("drain_r", q_r.size(), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        #3 arst = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_done_err", done_err, 1'b0);
        @(posedge aclk);
        @(posedge aclk);
        #1 arst = 1'b1;
        #1 check("rel_cmd_ready", cmd_ready, 1'b1);

        // Write id=3 addr=0x100 len=3 size=2, awready after 2 cycles.
        q_done.push_back('{id: 4'd3, resp: 2'b00, err: 1'b0});
        send_cmd(1'b1, 4'd3, 32'h100, 4'd3, 3'd2);
        wr_valid = 1'b1; wready = 1'b1; wr_data = 32'hDEAD_0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            check("t1_awvalid", awvalid, 1'b1);
            check("t1_wvalid_pre_aw", wvalid, 1'b0);
            check("t1_cmd_busy", cmd_ready, 1'b0);
            check("t1_awaddr", awaddr, 32'h100);
            check("t1_awid", awid, 4'd3);
            check("t1_awsize", awsize, 3'd2);
            check("t1_awburst", awburst, 2'b01);
            tick();
        end
        wait_aw(32'h100, 4'd3);
        write_beats(32'hA000_0000, 0, 4, 3, -1);
        b_resp(4'd3, 2'b00);
        drain();

        // Read id=5 addr=0x200 len=1, rresp 00 then 10.
        q_done.push_back('{id: 4'd5, resp: 2'b10, err: 1'b0});
        send_cmd(1'b0, 4'd5, 32'h200, 4'd1, 3'd2);
        wait_ar(32'h200, 4'd1);
        r_beat(4'd5, 32'h1111_2222, 2'b00, 1'b0);
        r_beat(4'd5, 32'h3333_4444, 2'b10, 1'b1);
        drain();

        // Read len=3 with rlast on beat 2.
        q_done.push_back('{id: 4'd6, resp: 2'b00, err: 1'b1});
        send_cmd(1'b0, 4'd6, 32'h300, 4'd3, 3'd2);
        wait_ar(32'h300, 4'd3);
        r_beat(4'd6, 32'h5555_0000, 2'b00, 1'b0);
        r_beat(4'd6, 32'h5555_0001, 2'b00, 1'b1);
        drain();

        // Write crossing 4KB: rejected, done next cycle, no AXI traffic.
        q_done.push_back('{id: 4'd7, resp: 2'b10, err: 1'b0});
        send_cmd(1'b1, 4'd7, 32'hFF8, 4'd3, 3'd2);
        @(negedge aclk);
        check("rej4k_done", done, 1'b1);
        check("rej4k_awvalid", awvalid, 1'b0);
        tick();
        drain();

        // Oversized beat: rejected the same way.
        q_done.push_back('{id: 4'd8, resp: 2'b10, err: 1'b0});
        send_cmd(1'b0, 4'd8, 32'h0, 4'd0, 3'd3);
        @(negedge aclk);
        check("rejsz_done", done, 1'b1);
        check("rejsz_arvalid", arvalid, 1'b0);
        tick();
        drain();

        // Write with a 3-cycle wr_valid gap before the third beat.
        q_done.push_back('{id: 4'd9, resp: 2'b00, err: 1'b0});
        send_cmd(1'b1, 4'd9, 32'h400, 4'd3, 3'd2);
        wait_aw(32'h400, 4'd3);
        write_beats(32'hB000_0000, 0, 4, 3, 2);
        b_resp(4'd9, 2'b00);
        drain();

        // Reset while the second write beat is pending.
        send_cmd(1'b1, 4'd10, 32'h500, 4'd3, 3'd2);
        wait_aw(32'h500, 4'd3);
        write_beats(32'hC000_0000, 0, 1, 3, -1);
        wr_valid = 1'b1; wready = 1'b0; wr_data = 32'hC000_0001;
        @(negedge aclk);
        check("pre_rst_wvalid", wvalid, 1'b1);
        #2 arst = 1'b0;
        #1;
        check("rst_wvalid_drop", wvalid, 1'b0);
        check("rst_awvalid_drop", awvalid, 1'b0);
        check("rst_done_none", done, 1'b0);
        wr_valid = 1'b0; wready = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        #1 arst = 1'b1;
        #1 check("rel2_cmd_ready", cmd_ready, 1'b1);
        q_done.push_back('{id: 4'd11, resp: 2'b00, err: 1'b0});
        send_cmd(1'b0, 4'd11, 32'h600, 4'd0, 3'd2);
        wait_ar(32'h600, 4'd0);
        r_beat(4'd11, 32'h7777_8888, 2'b00, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
